// File: rtl/apb_req_arbiter_pkg.sv
// apb_arb_pkg: shared types and defaults for the APB request arbiter.
//   arb_state_e  - sequencer FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   ADDR_W_DEF   - default APB address width
//   DATA_W_DEF   - default APB data width
//   apb_req_t    - one requester's transaction (rw, addr, wdata) at default widths
package apb_arb_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic                  rw;     // 1 = read
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick.
//   req      in  N   - request vector
//   last     in  IW  - index granted last time; search starts at last+1
//   gnt      out N   - one-hot grant (zero when no request)
//   gnt_idx  out IW  - index of the granted bit
//   gnt_any  out 1   - some request is set
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  int idx;

  // Walk N slots starting just above the last winner; the first set bit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!gnt_any && req[idx]) begin
        gnt_any      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter/sequencer in front of a single APB master.
// Accepts one request at a time, issues it as a one-cycle transfer, waits for
// xfer_done, then returns read data / PSLVERR to the issuing requester.
//   PCLK, PRESETn                 clock, async active-low reset
//   req_valid/rw/addr/wdata       per-requester request (packed buses)
//   req_ready                     one-hot accept strobe (combinational, IDLE only)
//   rsp_valid/rsp_rdata/rsp_err   one-hot completion strobe + shared response
//   transfer, READ_WRITE,
//   apb_write_paddr/data,
//   apb_read_paddr                request port of the APB master
//   apb_read_data_out, PSLVERR,
//   xfer_done                     completion from the APB master
// Optional: APB_ARB_TIMEOUT_EN compiles in a WAIT watchdog of TIMEOUT_CYCLES.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      transfer,
  output logic                      READ_WRITE,
  output logic [ADDR_W-1:0]         apb_write_paddr,
  output logic [DATA_W-1:0]         apb_write_data,
  output logic [ADDR_W-1:0]         apb_read_paddr,
  input  logic [DATA_W-1:0]         apb_read_data_out,
  input  logic                      PSLVERR,
  input  logic                      xfer_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       cur;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (req_valid),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign sel_rw    = req_rw[gnt_idx];
  assign sel_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];

  // Only IDLE samples requests, so the arbiter result is masked elsewhere.
  assign req_ready = (state == ST_IDLE) ? gnt : '0;

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] wdog;
  // Counter value seen in the Nth WAIT cycle is N-1.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
`endif

  // The APB-side outputs double as the latched request: they are loaded at
  // the accept edge and held until the next grant.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state           <= ST_IDLE;
      last_grant      <= IW'(NUM_REQ - 1);
      cur             <= '0;
      transfer        <= 1'b0;
      READ_WRITE      <= 1'b1;
      apb_write_paddr <= '0;
      apb_write_data  <= '0;
      apb_read_paddr  <= '0;
      rsp_valid       <= '0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      wdog            <= '0;
`endif
    end else begin
      transfer  <= 1'b0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: if (gnt_any) begin
          last_grant <= gnt_idx;
          cur        <= gnt_idx;
          transfer   <= 1'b1;
          READ_WRITE <= sel_rw;
          if (sel_rw) begin
            apb_read_paddr  <= sel_addr;
            apb_write_paddr <= '0;
            apb_write_data  <= '0;
          end else begin
            apb_read_paddr  <= '0;
            apb_write_paddr <= sel_addr;
            apb_write_data  <= sel_wdata;
          end
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
`ifdef APB_ARB_TIMEOUT_EN
          wdog  <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // xfer_done takes priority over a coincident watchdog expiry.
          if (xfer_done) begin
            rsp_rdata <= READ_WRITE ? apb_read_data_out : '0;
            rsp_err   <= PSLVERR;
            rsp_valid <= NUM_REQ'(1) << cur;
            state     <= ST_RESP;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (wdog == WDOG_LAST) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << cur;
            state     <= ST_RESP;
          end else begin
            wdog <= wdog + 8'd1;
          end
`endif
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (NUM_REQ=4, ADDR_W=9, DATA_W=8,
// TIMEOUT_CYCLES=8). Inputs change 1 ns after the rising edge and outputs are
// sampled there too, well away from the next active edge.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [3:0]  req_valid, req_rw, req_ready, rsp_valid;
  logic [35:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  rsp_rdata, apb_write_data, apb_read_data_out;
  logic        rsp_err, transfer, READ_WRITE, PSLVERR, xfer_done;
  logic [8:0]  apb_write_paddr, apb_read_paddr;

  int n_chk  = 0;
  int n_fail = 0;
  int n_xfer = 0;
  int x0;

  apb_req_arbiter #(.NUM_REQ(4), .ADDR_W(9), .DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
    .PSLVERR(PSLVERR), .xfer_done(xfer_done)
  );

  always #5 PCLK = ~PCLK;

  // Count cycles in which transfer is high (one per issued request).
  always @(posedge PCLK) if (transfer === 1'b1) n_xfer++;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input apb_req_t r);
    req_rw[i]            = r.rw;
    req_addr[i*9 +: 9]   = r.addr;
    req_wdata[i*8 +: 8]  = r.wdata;
  endtask

  initial begin
    PRESETn = 1'b0; req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    apb_read_data_out = '0; PSLVERR = 1'b0; xfer_done = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_transfer", 32'(transfer), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rw", 32'(READ_WRITE), 1);
    check("rst_addr", 32'({apb_write_paddr, apb_read_paddr, apb_write_data}), 0);
    PRESETn = 1'b1;
    tick();

    // Single read from requester 2, done 2 cycles after transfer
    set_req(2, '{rw: 1'b1, addr: 9'h1A5, wdata: 8'h00});
    req_valid = 4'b0100; #1;
    check("rd_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    check("rd_transfer", 32'(transfer), 1);
    check("rd_rw", 32'(READ_WRITE), 1);
    check("rd_rpaddr", 32'(apb_read_paddr), 32'h1A5);
    check("rd_wr_zero", 32'({apb_write_paddr, apb_write_data}), 0);
    check("rd_ready_issue", 32'(req_ready), 0);
    tick();
    check("rd_wait_transfer", 32'(transfer), 0);
    check("rd_wait_rpaddr", 32'(apb_read_paddr), 32'h1A5);
    check("rd_wait_rsp", 32'(rsp_valid), 0);
    tick(); xfer_done = 1'b1; apb_read_data_out = 8'h3C;
    tick(); xfer_done = 1'b0; apb_read_data_out = 8'h00;
    check("rd_rsp_valid", 32'(rsp_valid), 32'h4);
    check("rd_rsp_rdata", 32'(rsp_rdata), 32'h3C);
    check("rd_rsp_err", 32'(rsp_err), 0);
    tick();
    check("rd_rsp_clear", 32'(rsp_valid), 0);
    check("rd_rdata_hold", 32'(rsp_rdata), 32'h3C);

    // Write from requester 0 with PSLVERR; early xfer_done in ISSUE is ignored
    set_req(0, '{rw: 1'b0, addr: 9'h010, wdata: 8'hA5});
    req_valid = 4'b0001; #1;
    check("wr_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; xfer_done = 1'b1;
    check("wr_transfer", 32'(transfer), 1);
    check("wr_rw", 32'(READ_WRITE), 0);
    check("wr_wpaddr", 32'(apb_write_paddr), 32'h010);
    check("wr_wdata", 32'(apb_write_data), 32'hA5);
    check("wr_rpaddr_zero", 32'(apb_read_paddr), 0);
    tick(); xfer_done = 1'b0;
    check("wr_issue_done_ignored", 32'(rsp_valid), 0);
    xfer_done = 1'b1; PSLVERR = 1'b1; apb_read_data_out = 8'hFF;
    tick(); xfer_done = 1'b0; PSLVERR = 1'b0; apb_read_data_out = 8'h00;
    check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check("wr_rsp_err", 32'(rsp_err), 1);
    check("wr_rsp_rdata", 32'(rsp_rdata), 0);
    tick();

    // All four held valid from reset: grant order 0,1,2,3,0
    PRESETn = 1'b0; tick(); PRESETn = 1'b1; tick();
    for (int i = 0; i < 4; i++) set_req(i, '{rw: 1'b0, addr: 9'(9'h040 + i), wdata: 8'(8'h10 + i)});
    req_valid = 4'b1111; x0 = n_xfer; #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      check($sformatf("rr_wpaddr_%0d", k), 32'(apb_write_paddr), 32'(9'h040 + (k % 4)));
      tick(); xfer_done = 1'b1; PSLVERR = (k == 4);
      tick(); xfer_done = 1'b0; PSLVERR = 1'b0;
      check($sformatf("rr_rsp_%0d", k), 32'(rsp_valid), 32'(1 << (k % 4)));
      tick();
    end
    req_valid = '0; tick();
    check("rr_xfer_pulses", 32'(n_xfer - x0), 5);

    // Reset asserted in WAIT drops the in-flight request
    set_req(1, '{rw: 1'b0, addr: 9'h1FF, wdata: 8'h77});
    req_valid = 4'b0010; #1;
    check("rw_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; tick();
    check("rw_wait_wpaddr", 32'(apb_write_paddr), 32'h1FF);
    #2 PRESETn = 1'b0; #1;
    check("arst_rw", 32'(READ_WRITE), 1);
    check("arst_addr", 32'({apb_write_paddr, apb_read_paddr, apb_write_data}), 0);
    check("arst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata, transfer}), 0);
    tick(); PRESETn = 1'b1; xfer_done = 1'b1;
    tick(); xfer_done = 1'b0;
    check("arst_no_stray_rsp", 32'(rsp_valid), 0);
    tick();
    check("arst_no_stray_rsp2", 32'(rsp_valid), 0);
    req_valid = 4'b1111; #1;
    check("arst_first_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; tick(); xfer_done = 1'b1;
    tick(); xfer_done = 1'b0;
    check("arst_rsp_valid", 32'(rsp_valid), 32'h1);
    tick();

    // Watchdog: requester 3 read, master never answers
    set_req(3, '{rw: 1'b1, addr: 9'h0AA, wdata: 8'h00});
    req_valid = 4'b1000; #1;
    check("to_ready", 32'(req_ready), 32'h8);
    tick(); req_valid = '0; tick();
`ifdef APB_ARB_TIMEOUT_EN
    for (int w = 1; w <= 8; w++) begin
      check($sformatf("to_wait_%0d", w), 32'(rsp_valid), 0);
      tick();
    end
    check("to_rsp_valid", 32'(rsp_valid), 32'h8);
    check("to_rsp_err", 32'(rsp_err), 1);
    check("to_rsp_rdata", 32'(rsp_rdata), 0);
    tick();
    // xfer_done in the 8th WAIT cycle wins over the expiry
    req_valid = 4'b1000; #1;
    tick(); req_valid = '0; tick();
    for (int w = 1; w < 8; w++) tick();
    xfer_done = 1'b1; PSLVERR = 1'b0; apb_read_data_out = 8'h5A;
    tick(); xfer_done = 1'b0; apb_read_data_out = 8'h00;
    check("to_race_valid", 32'(rsp_valid), 32'h8);
    check("to_race_err", 32'(rsp_err), 0);
    check("to_race_rdata", 32'(rsp_rdata), 32'h5A);
`else
    for (int w = 1; w <= 20; w++) begin
      check($sformatf("nowd_wait_%0d", w), 32'(rsp_valid), 0);
      tick();
    end
    xfer_done = 1'b1; PSLVERR = 1'b0; apb_read_data_out = 8'h5A;
    tick(); xfer_done = 1'b0; apb_read_data_out = 8'h00;
    check("nowd_rsp_valid", 32'(rsp_valid), 32'h8);
    check("nowd_rsp_err", 32'(rsp_err), 0);
    check("nowd_rsp_rdata", 32'(rsp_rdata), 32'h5A);
`endif
    tick();
    check("final_rsp_clear", 32'(rsp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter and sequencer that shares the single APB master request port (`transfer`, `READ_WRITE`, `apb_write_paddr`, `apb_write_data`, `apb_read_paddr`) between `NUM_REQ` on-chip requesters. It accepts one request at a time and drives it onto the APB master. It waits for the master's completion pulse, then returns read data and `PSLVERR` status to the requester that issued it. It sits directly in front of the APB master inside the APB subsystem top.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 9: APB address width.
- `DATA_W`, 8: APB data width.
- `TIMEOUT_CYCLES`, 64: WAIT-state watchdog limit, 1..255. Used only when the watchdog is compiled in.

Ports:
- `PCLK` in 1: clock; all logic on the rising edge.
- `PRESETn` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester request pending; held until `req_ready`.
- `req_rw` in `NUM_REQ`: per-requester direction; 1 = read, 0 = write.
- `req_addr` in `NUM_REQ*ADDR_W`: packed addresses; requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata` in `NUM_REQ*DATA_W`: packed write data, same packing.
- `req_ready` out `NUM_REQ`: one-hot, one-cycle accept strobe.
- `rsp_valid` out `NUM_REQ`: one-hot, one-cycle completion strobe.
- `rsp_rdata` out `DATA_W`: read data; valid while `rsp_valid` is nonzero.
- `rsp_err` out 1: error status; valid while `rsp_valid` is nonzero.
- `transfer` out 1: request to the APB master.
- `READ_WRITE` out 1: direction to the APB master; 1 = read.
- `apb_write_paddr` out `ADDR_W`: write address to the APB master.
- `apb_write_data` out `DATA_W`: write data to the APB master.
- `apb_read_paddr` out `ADDR_W`: read address to the APB master.
- `apb_read_data_out` in `DATA_W`: read data from the APB master.
- `PSLVERR` in 1: slave error from the APB master.
- `xfer_done` in 1: one-cycle pulse from the APB master when its transfer ends; `apb_read_data_out` and `PSLVERR` are valid in the same cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is set, grant the first set bit searching upward, with wrap, from `last_grant+1`.
  - `req_ready[g]` is asserted combinationally in this cycle.
  - The granted request's rw, addr and wdata are latched at the edge; `last_grant <= g`; go to ISSUE.
- **ISSUE**
  - `transfer=1` for exactly one cycle.
  - `READ_WRITE` = latched rw.
  - On a read, `apb_read_paddr` = latched addr and `apb_write_paddr`/`apb_write_data` = 0.
  - On a write, `apb_write_paddr`/`apb_write_data` = latched values and `apb_read_paddr` = 0.
  - Go to WAIT.
- **WAIT**
  - `transfer=0`; address, data and `READ_WRITE` stay stable.
  - On `xfer_done`, latch `rsp_rdata`:
    - read: `apb_read_data_out`;
    - write: 0.
  - On `xfer_done`, `rsp_err <= PSLVERR`; go to RESP.
- **RESP**
  - `rsp_valid[g]=1` for one cycle, then IDLE.
  - `rsp_rdata` and `rsp_err` hold until the next RESP.
- Requests are only sampled in IDLE; new requests are never accepted in ISSUE, WAIT or RESP.
- `xfer_done` outside WAIT is ignored.
- Reset values:
  - state IDLE, `last_grant = NUM_REQ-1` (so requester 0 wins first);
  - `transfer`, `req_ready`, `rsp_valid`, `rsp_err`, `rsp_rdata`, all addresses and data = 0;
  - `READ_WRITE = 1`.
- Reset mid-transfer drops the in-flight request silently; no `rsp_valid` is generated for it.

## Timing
- Request accepted at edge 0.
- `transfer` high in cycle 1.
- Earliest `xfer_done` in cycle 2.
- `rsp_valid` in the cycle after `xfer_done`.
- Next grant at the earliest in the cycle after RESP.
- Minimum request-to-response latency is 3 cycles; minimum back-to-back issue spacing is 4 cycles.
- All requester outputs are registered except `req_ready`.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `xfer_done`, go to RESP with `rsp_err=1` and `rsp_rdata=0`.
  - If `xfer_done` coincides with the timeout, `xfer_done` wins.
- Undefined: no counter; WAIT persists until `xfer_done`.

## Structure
- Package `apb_arb_pkg` holds:
  - the FSM state enum `arb_state_e`;
  - the `ADDR_W`/`DATA_W` default constants;
  - the request struct `apb_req_t` (rw, addr, wdata).
- Sub-module `rr_arbiter`: combinational rotating-priority pick. Inputs: request vector and `last_grant`. Outputs: one-hot grant and index.

## Test plan
- Single read from requester 2 at addr `9'h1A5`, master returns `8'h3C` with `xfer_done` 2 cycles after `transfer` → `READ_WRITE=1`, `apb_read_paddr=9'h1A5`, `rsp_valid=4'b0100`, `rsp_rdata=8'h3C`, `rsp_err=0`.
- Write from requester 0, addr `9'h010`, data `8'hA5`, `PSLVERR=1` at done → `apb_write_paddr=9'h010`, `apb_write_data=8'hA5`, `rsp_err=1`, `rsp_rdata=0`.
- All four requesters held valid from reset → grant order 0,1,2,3,0; exactly one `transfer` pulse per grant.
- Reset asserted in WAIT → all outputs at reset values asynchronously; after release, requester 0 is granted first; no stray `rsp_valid`.
- With `APB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`, no `xfer_done` → `rsp_err=1` exactly 8 WAIT cycles after ISSUE; a second run with `xfer_done` in the 8th WAIT cycle → `rsp_err=PSLVERR`.
